axi_burst_ptgen_master: RTL

- AXI4 full-burst master pattern generator driving the M00_AXI port of the burst-test IP.
- On a rising edge of INIT_AXI_TXN it writes NUM_BURSTS incrementing-pattern bursts to the target slave, reads them back and compares every beat.
- Reports completion on TXN_DONE and any failure on ERROR.
- Its AXI master interface is consumed directly by the downstream slave: the slave memory VIP in simulation, the DDR/BRAM interconnect in the C64 system.

---
 rtl/axi_burst_ptgen_master_pkg.sv | 8 +
 rtl/axi_burst_ptgen_master_if.sv | 31 +++
 rtl/axi_burst_ptgen_master_beat_ctr.sv | 28 ++
 rtl/axi_burst_ptgen_master.sv | 129 ++++++++++++
 4 files changed

// File: rtl/axi_burst_ptgen_master_pkg.sv
// axi_burst_pkg: AXI encodings and FSM state type shared by the burst pattern generator.
package axi_burst_pkg;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
endpackage

// File: rtl/axi_burst_ptgen_master_if.sv
// axi_burst_ptgen_master_if: AXI4 full-burst bus between the pattern generator and its slave.
interface axi_burst_ptgen_master_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID, AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST, WVALID, WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID, BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID, ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST, RVALID, RREADY;
    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
               ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );
    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
               ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_burst_ptgen_master_beat_ctr.sv
// axi_burst_beat_ctr: beat-in-burst, burst and global beat counters for one data path.
module axi_burst_beat_ctr #(parameter int BURST_LEN = 8, parameter int NUM_BURSTS = 4) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        adv_i,
    output logic        last_o,
    output logic [6:0]  burst_o,
    output logic [14:0] idx_o
);
    logic [7:0]  beat_q;
    logic [6:0]  burst_q;
    logic [14:0] idx_q;
    assign last_o  = int'(beat_q) == BURST_LEN - 1;
    assign burst_o = burst_q;
    assign idx_o   = idx_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr_i) begin
            beat_q  <= '0;
            burst_q <= '0;
            idx_q   <= '0;
        end else if (adv_i) begin
            beat_q  <= last_o ? 8'd0 : beat_q + 8'd1;
            burst_q <= last_o ? burst_q + 7'd1 : burst_q;
            idx_q   <= idx_q + 15'd1;
        end
    end
endmodule

// File: rtl/axi_burst_ptgen_master.sv
// axi_burst_ptgen_master: writes NUM_BURSTS incrementing bursts, reads them back and flags any mismatch.
module axi_burst_ptgen_master
    import axi_burst_pkg::*;
#(
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] TARGET_BASE_ADDR = 32'h4000_0000,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    BURST_LEN        = 8,
    parameter int                    NUM_BURSTS       = 4
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic INIT_AXI_TXN,
    output logic TXN_DONE,
    output logic ERROR,
    axi_burst_ptgen_master_if.master m_axi
);
    state_e                state_q;
    logic                  init_q, init_qq, done_q, error_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  start, w_hs, r_hs, w_last, r_last;
    logic [6:0]            w_burst, r_burst;
    logic [14:0]           w_idx, r_idx;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [6:0] b);
        return TARGET_BASE_ADDR + ADDR_WIDTH'(b) * ADDR_WIDTH'(BURST_LEN * 4);
    endfunction

    assign start = init_q & ~init_qq & (state_q == IDLE || state_q == DONE);
    assign w_hs  = wvalid_q & m_axi.WREADY;
    assign r_hs  = rready_q & m_axi.RVALID;

    axi_burst_beat_ctr #(.BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS)) u_wctr (
        .clk(ACLK), .rst_n(ARESETN), .clr_i(start), .adv_i(w_hs),
        .last_o(w_last), .burst_o(w_burst), .idx_o(w_idx)
    );
    axi_burst_beat_ctr #(.BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS)) u_rctr (
        .clk(ACLK), .rst_n(ARESETN), .clr_i(start), .adv_i(r_hs),
        .last_o(r_last), .burst_o(r_burst), .idx_o(r_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            {init_q, init_qq, done_q, error_q} <= '0;
            {awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q} <= '0;
            awaddr_q  <= TARGET_BASE_ADDR;
            araddr_q  <= TARGET_BASE_ADDR;
            wdata_q   <= '0;
        end else begin
            init_q  <= INIT_AXI_TXN;
            init_qq <= init_q;
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q   <= WRITE;
                    done_q    <= 1'b0;
                    error_q   <= 1'b0;
                    awvalid_q <= 1'b1;
                    awaddr_q  <= TARGET_BASE_ADDR;
                    wvalid_q  <= 1'b1;
                    wdata_q   <= DATA_WIDTH'(1);
                end
                WRITE: begin
                    if (m_axi.AWREADY) awvalid_q <= 1'b0;
                    if (w_hs) begin
                        wdata_q <= DATA_WIDTH'(w_idx + 15'd2);
                        if (w_last) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                        end
                    end
                    // w_burst has already advanced past the burst being acknowledged
                    if (bready_q && m_axi.BVALID) begin
                        bready_q <= 1'b0;
                        if ((m_axi.BRESP & RESP_SLVERR) != RESP_OKAY) error_q <= 1'b1;
                        if (int'(w_burst) == NUM_BURSTS) begin
                            state_q   <= READ;
                            arvalid_q <= 1'b1;
                            araddr_q  <= TARGET_BASE_ADDR;
                            rready_q  <= 1'b1;
                        end else begin
                            awvalid_q <= 1'b1;
                            awaddr_q  <= burst_addr(w_burst);
                            wvalid_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (m_axi.ARREADY) arvalid_q <= 1'b0;
                    if (r_hs) begin
                        if (m_axi.RDATA != DATA_WIDTH'(r_idx + 15'd1) || m_axi.RRESP[1] || m_axi.RLAST != r_last)
                            error_q <= 1'b1;
                        if (r_last) begin
                            if (int'(r_burst) == NUM_BURSTS - 1) begin
                                state_q  <= DONE;
                                rready_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                arvalid_q <= 1'b1;
                                araddr_q  <= burst_addr(r_burst + 7'd1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign m_axi.AWADDR  = awaddr_q;
    assign m_axi.AWLEN   = 8'(BURST_LEN - 1);
    assign m_axi.AWSIZE  = SIZE_4B;
    assign m_axi.AWBURST = BURST_INCR;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = '1;
    assign m_axi.WLAST   = wvalid_q & w_last;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARLEN   = 8'(BURST_LEN - 1);
    assign m_axi.ARSIZE  = SIZE_4B;
    assign m_axi.ARBURST = BURST_INCR;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;
endmodule
